uart_io: RTL and testbench
==========================

UART_IO -- requirements
Module: uart_io

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal values: even, >= 4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port readEnable  input  1  peripheral select from the address decoder; level, no read side effects.
REQ-005 SHALL have port writeEnable  input  1  write strobe; one write per cycle it is high.
REQ-006 SHALL have port regSelect  input  2  register index: 00 TXDATA, 01 RXDATA, 10 CONTROL, 11 STATUS.
REQ-007 SHALL have port dataIn  input  8  CPU write data.
REQ-008 SHALL have port dataOut  output  8  CPU read data.
REQ-009 SHALL have port rx  input  1  serial receive line, asynchronous, idle high.
REQ-010 SHALL have port tx  output  1  serial transmit line, idle high.

Function
REQ-011 dataOut SHALL be combinational: selected register when readEnable=1, else 8'h00.
REQ-012 TXDATA (00): R/W; a write loads dataIn; a read returns the last value written.
REQ-013 RXDATA (01): read-only last accepted received byte; writes ignored.
REQ-014 CONTROL (10): bit0 txStart (write-1 pulse, reads 0); bit1 rxEnable (R/W); bits7:2 read 0.
REQ-015 STATUS (11): bit0 txBusy, bit1 rxValid, bit2 rxOverrun, bit3 rxFrameError; bits7:4 read 0.
REQ-016 STATUS writes SHALL be write-1-to-clear for bits 3:1; bit0 is unaffected.
REQ-017 Reads SHALL never change state.
REQ-018 TX FSM states IDLE, START, DATA, STOP; each bit held on tx for exactly CLKS_PER_BIT cycles.
REQ-019 A CONTROL write with dataIn[0]=1 in IDLE SHALL copy TXDATA into the shift register and enter START; txBusy=1 and tx=0 from the next cycle.
REQ-020 Frame SHALL be 8N1: start bit 0, data LSB first, one stop bit 1; after the stop bit, FSM returns to IDLE and txBusy=0.
REQ-021 txStart while txBusy=1 SHALL be ignored; TXDATA writes while busy do not affect the frame in flight.
REQ-022 rx SHALL pass through a 2-flop synchronizer before use.
REQ-023 RX FSM states IDLE, START, DATA, STOP; it remains in IDLE while rxEnable=0.
REQ-024 A falling edge of synchronized rx in IDLE SHALL enter START; rx is sampled at CLKS_PER_BIT/2 cycles into START.
REQ-025 If the START sample is 1 (glitch), the FSM SHALL return to IDLE with no flag change.
REQ-026 Data bits SHALL be sampled every CLKS_PER_BIT cycles after the START sample, LSB first; the stop bit is sampled one interval after bit 7.
REQ-027 Stop sample 0: set rxFrameError, discard byte, leave RXDATA/rxValid unchanged, return to IDLE.
REQ-028 Stop sample 1 with rxValid=0: load RXDATA and set rxValid.
REQ-029 Stop sample 1 with rxValid=1: keep old RXDATA, drop the new byte, set rxOverrun.
REQ-030 If a flag-setting event and a W1C clear of that flag occur in the same cycle, set SHALL win.
REQ-031 Clearing rxEnable mid-frame SHALL abort RX to IDLE with no flag change; TX is unaffected.

Reset
REQ-032 On rst=1 at a clock edge, both FSMs SHALL enter IDLE and baud counters clear.
REQ-033 On reset, tx=1, TXDATA=00, RXDATA=00, rxEnable=1, and all STATUS bits=0; dataOut follows REQ-011.
REQ-034 Reset asserted mid-frame SHALL abort the frame, with tx=1 on the cycle after the reset edge.

Verification (CLKS_PER_BIT=4)
REQ-035 TX: write 8'hA5 to TXDATA, then 8'h01 to CONTROL -> tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; txBusy is 1 for 40 cycles.
REQ-036 RX: drive frame 8'h3C on rx -> after the stop sample, STATUS=8'h02 and RXDATA=8'h3C; write 8'h02 to STATUS -> STATUS=8'h00.
REQ-037 Overrun and frame error: send 8'h11 then 8'h22 without clearing -> RXDATA=8'h11 and STATUS bit2=1; send a frame with stop=0 -> bit3=1 and RXDATA unchanged.
REQ-038 Glitch: a 1-cycle low pulse on rx -> no flag change, and RX returns to IDLE.
REQ-039 Busy and collision: txStart while busy is ignored, and the frame completes with the original data; a W1C of rxValid in the same cycle a new byte lands leaves rxValid=1.
REQ-040 Reset mid-TX frame -> tx=1 on the next cycle, and STATUS=8'h00.

Source files
------------

// File: rtl/uart_io_if.sv
// rtl/uart_io_if.sv - CPU register bus bundle for the UART peripheral.
interface uart_io_if;
  logic       readEnable;
  logic       writeEnable;
  logic [1:0] regSelect;
  logic [7:0] dataIn;
  logic [7:0] dataOut;

  modport master (
    output readEnable, writeEnable, regSelect, dataIn,
    input  dataOut
  );

  modport slave (
    input  readEnable, writeEnable, regSelect, dataIn,
    output dataOut
  );
endinterface

// File: rtl/uart_io.sv
// rtl/uart_io.sv - 8N1 UART with a four-register CPU interface.
// TX and RX FSMs share one bit-period counter width; RX samples mid-bit after a 2-flop synchronizer.
module uart_io #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_io_if.slave  bus,
  input  logic      rx,
  output logic      tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  logic [7:0] txData;
  logic [7:0] rxData;
  logic       rxEnable;
  logic       rxValid;
  logic       rxOverrun;
  logic       rxFrameError;
  logic       txBusy;

  logic wrTx;
  logic wrCtrl;
  logic wrStat;

  assign wrTx   = bus.writeEnable && (bus.regSelect == 2'b00);
  assign wrCtrl = bus.writeEnable && (bus.regSelect == 2'b10);
  assign wrStat = bus.writeEnable && (bus.regSelect == 2'b11);

  // ---------------- transmitter ----------------
  txState_t      txState, txStateNext;
  logic [CW-1:0] txCnt, txCntNext;
  logic [2:0]    txBit, txBitNext;
  logic [7:0]    txShift, txShiftNext;
  logic          txOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      txState <= TX_IDLE;
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
    end else begin
      txState <= txStateNext;
      txCnt   <= txCntNext;
      txBit   <= txBitNext;
      txShift <= txShiftNext;
    end
  end

  always_comb begin
    txStateNext = txState;
    txCntNext   = txCnt;
    txBitNext   = txBit;
    txShiftNext = txShift;
    txOut       = 1'b1;
    case (txState)
      TX_IDLE: begin
        if (wrCtrl && bus.dataIn[0]) begin
          txStateNext = TX_START;
          txCntNext   = '0;
          txBitNext   = '0;
          txShiftNext = txData;
        end
      end
      TX_START: begin
        txOut = 1'b0;
        if (txCnt == CNT_LAST) begin
          txStateNext = TX_DATA;
          txCntNext   = '0;
        end else begin
          txCntNext = txCnt + 1'b1;
        end
      end
      TX_DATA: begin
        txOut = txShift[0];
        if (txCnt == CNT_LAST) begin
          txCntNext   = '0;
          txShiftNext = {1'b0, txShift[7:1]};
          if (txBit == 3'd7) txStateNext = TX_STOP;
          else               txBitNext   = txBit + 1'b1;
        end else begin
          txCntNext = txCnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (txCnt == CNT_LAST) begin
          txStateNext = TX_IDLE;
          txCntNext   = '0;
        end else begin
          txCntNext = txCnt + 1'b1;
        end
      end
      default: txStateNext = TX_IDLE;
    endcase
  end

  assign tx     = txOut;
  assign txBusy = (txState != TX_IDLE);

  // ---------------- receiver ----------------
  logic rxSync1, rxSync2, rxPrev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxPrev  <= 1'b1;
    end else begin
      rxSync1 <= rx;
      rxSync2 <= rxSync1;
      rxPrev  <= rxSync2;
    end
  end

  rxState_t      rxState, rxStateNext;
  logic [CW-1:0] rxCnt, rxCntNext;
  logic [2:0]    rxBit, rxBitNext;
  logic [7:0]    rxShift, rxShiftNext;
  logic          rxDone;
  logic          rxBad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxState <= RX_IDLE;
      rxCnt   <= '0;
      rxBit   <= '0;
      rxShift <= '0;
    end else begin
      rxState <= rxStateNext;
      rxCnt   <= rxCntNext;
      rxBit   <= rxBitNext;
      rxShift <= rxShiftNext;
    end
  end

  always_comb begin
    rxStateNext = rxState;
    rxCntNext   = rxCnt;
    rxBitNext   = rxBit;
    rxShiftNext = rxShift;
    rxDone      = 1'b0;
    rxBad       = 1'b0;
    if (!rxEnable) begin
      // Disabling the receiver abandons any partial frame silently.
      rxStateNext = RX_IDLE;
      rxCntNext   = '0;
    end else begin
      case (rxState)
        RX_IDLE: begin
          if (rxPrev && !rxSync2) begin
            rxStateNext = RX_START;
            rxCntNext   = '0;
          end
        end
        RX_START: begin
          if (rxCnt == CNT_HALF) begin
            rxCntNext   = '0;
            rxBitNext   = '0;
            rxStateNext = rxSync2 ? RX_IDLE : RX_DATA;
          end else begin
            rxCntNext = rxCnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rxCnt == CNT_LAST) begin
            rxCntNext   = '0;
            rxShiftNext = {rxSync2, rxShift[7:1]};
            if (rxBit == 3'd7) rxStateNext = RX_STOP;
            else               rxBitNext   = rxBit + 1'b1;
          end else begin
            rxCntNext = rxCnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rxCnt == CNT_LAST) begin
            rxStateNext = RX_IDLE;
            rxCntNext   = '0;
            rxDone      = rxSync2;
            rxBad       = !rxSync2;
          end else begin
            rxCntNext = rxCnt + 1'b1;
          end
        end
        default: rxStateNext = RX_IDLE;
      endcase
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      txData       <= '0;
      rxData       <= '0;
      rxEnable     <= 1'b1;
      rxValid      <= 1'b0;
      rxOverrun    <= 1'b0;
      rxFrameError <= 1'b0;
    end else begin
      if (wrTx)   txData   <= bus.dataIn;
      if (wrCtrl) rxEnable <= bus.dataIn[1];
      // Flag set terms are OR'd after the W1C mask so a simultaneous event wins.
      rxValid      <= (rxDone && !rxValid) || (rxValid && !(wrStat && bus.dataIn[1]));
      rxOverrun    <= (rxDone && rxValid) || (rxOverrun && !(wrStat && bus.dataIn[2]));
      rxFrameError <= rxBad || (rxFrameError && !(wrStat && bus.dataIn[3]));
      if (rxDone && !rxValid) rxData <= rxShift;
    end
  end

  logic [7:0] readData;

  always_comb begin
    readData = 8'h00;
    if (bus.readEnable) begin
      case (bus.regSelect)
        2'b00:   readData = txData;
        2'b01:   readData = rxData;
        2'b10:   readData = {6'b0, rxEnable, 1'b0};
        default: readData = {4'b0, rxFrameError, rxOverrun, rxValid, txBusy};
      endcase
    end
  end

  assign bus.dataOut = readData;

endmodule

// File: tb/tb_uart_io.sv
// tb/tb_uart_io.sv - scoreboard bench for uart_io with CLKS_PER_BIT=4.
module tb_uart_io;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  uart_io_if bus ();

  uart_io #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .rx  (rx),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic       txQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] modelRxData;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic busWrite(input logic [1:0] r, input logic [7:0] d);
    @(negedge clk);
    bus.writeEnable = 1'b1;
    bus.regSelect   = r;
    bus.dataIn      = d;
    @(negedge clk);
    bus.writeEnable = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] r, output logic [7:0] d);
    bus.readEnable = 1'b1;
    bus.regSelect  = r;
    #1;
    d = bus.dataOut;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pushTxFrame(input logic [7:0] b);
    for (int k = 0; k < CPB; k++) txQ.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CPB; k++) txQ.push_back(b[i]);
    for (int k = 0; k < CPB; k++) txQ.push_back(1'b1);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkCount++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passCount++;
    bus.readEnable = 1'b0;
    bus.regSelect  = 2'b11;
    #1;
    checkCount++;
    if (bus.dataOut !== 8'h00) $display("FAIL reset_noread: got %h want 00", bus.dataOut); else passCount++;
    busRead(2'b00, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL reset_txdata: got %h want 00", v); else passCount++;
    busRead(2'b01, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL reset_rxdata: got %h want 00", v); else passCount++;
    busRead(2'b10, v);
    checkCount++;
    if (v !== 8'h02) $display("FAIL reset_control: got %h want 02", v); else passCount++;
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL reset_status: got %h want 00", v); else passCount++;
    modelRxData = 8'h00;
  endtask

  task automatic test_tx;
    logic [7:0] v;
    logic       e;
    busWrite(2'b00, 8'hA5);
    busRead(2'b00, v);
    checkCount++;
    if (v !== 8'hA5) $display("FAIL txdata_readback: got %h want a5", v); else passCount++;
    pushTxFrame(8'hA5);
    busWrite(2'b10, 8'h01);
    for (int i = 0; i < 10 * CPB; i++) begin
      e = txQ.pop_front();
      checkCount++;
      if (tx !== e) $display("FAIL tx_bit sample %0d: got %b want %b", i, tx, e); else passCount++;
      busRead(2'b11, v);
      checkCount++;
      if (v[0] !== 1'b1) $display("FAIL tx_busy sample %0d: got %b want 1", i, v[0]); else passCount++;
      @(negedge clk);
    end
    checkCount++;
    if (tx !== 1'b1) $display("FAIL tx_idle_after: got %b want 1", tx); else passCount++;
    busRead(2'b11, v);
    checkCount++;
    if (v[0] !== 1'b0) $display("FAIL tx_busy_after: got %b want 0", v[0]); else passCount++;
    busRead(2'b10, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL control_rxen_cleared: got %h want 00", v); else passCount++;
    busWrite(2'b10, 8'h02);
  endtask

  task automatic test_rx;
    logic [7:0] v;
    rxQ.push_back(8'h3C);
    modelRxData = 8'h3C;
    sendFrame(8'h3C, 1'b1);
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h02) $display("FAIL rx_status: got %h want 02", v); else passCount++;
    busRead(2'b01, v);
    checkCount++;
    if (v !== rxQ[0]) $display("FAIL rx_data: got %h want %h", v, rxQ[0]); else passCount++;
    void'(rxQ.pop_front());
    busWrite(2'b01, 8'hEE);
    busRead(2'b01, v);
    checkCount++;
    if (v !== modelRxData) $display("FAIL rxdata_readonly: got %h want %h", v, modelRxData); else passCount++;
    busWrite(2'b11, 8'h02);
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL rx_w1c: got %h want 00", v); else passCount++;
  endtask

  task automatic test_overrun_frame;
    logic [7:0] v;
    rxQ.push_back(8'h11);
    modelRxData = 8'h11;
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
    busRead(2'b01, v);
    checkCount++;
    if (v !== rxQ[0]) $display("FAIL overrun_data: got %h want %h", v, rxQ[0]); else passCount++;
    void'(rxQ.pop_front());
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h06) $display("FAIL overrun_status: got %h want 06", v); else passCount++;
    sendFrame(8'h55, 1'b0);
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h0E) $display("FAIL frame_status: got %h want 0e", v); else passCount++;
    busRead(2'b01, v);
    checkCount++;
    if (v !== modelRxData) $display("FAIL frame_data: got %h want %h", v, modelRxData); else passCount++;
    busWrite(2'b11, 8'h0F);
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL flags_clear: got %h want 00", v); else passCount++;
  endtask

  task automatic test_glitch;
    logic [7:0] v;
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL glitch_status: got %h want 00", v); else passCount++;
    rxQ.push_back(8'h96);
    modelRxData = 8'h96;
    sendFrame(8'h96, 1'b1);
    busRead(2'b01, v);
    checkCount++;
    if (v !== rxQ[0]) $display("FAIL glitch_next_data: got %h want %h", v, rxQ[0]); else passCount++;
    void'(rxQ.pop_front());
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h02) $display("FAIL glitch_next_status: got %h want 02", v); else passCount++;
    busWrite(2'b11, 8'h02);
  endtask

  task automatic test_abort;
    logic [7:0] v;
    fork
      sendFrame(8'hFF, 1'b1);
      begin
        repeat (14) @(negedge clk);
        busWrite(2'b10, 8'h00);
        busWrite(2'b10, 8'h02);
      end
    join
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL abort_status: got %h want 00", v); else passCount++;
    busRead(2'b01, v);
    checkCount++;
    if (v !== modelRxData) $display("FAIL abort_data: got %h want %h", v, modelRxData); else passCount++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    logic       e;
    logic       seen;
    int         waited;
    busWrite(2'b00, 8'h5A);
    pushTxFrame(8'h5A);
    busWrite(2'b10, 8'h03);
    fork
      for (int i = 0; i < 10 * CPB; i++) begin
        e = txQ.pop_front();
        checkCount++;
        if (tx !== e) $display("FAIL busy_tx_bit sample %0d: got %b want %b", i, tx, e); else passCount++;
        @(negedge clk);
      end
      begin
        repeat (8) @(negedge clk);
        busWrite(2'b00, 8'hFF);
        busWrite(2'b10, 8'h03);
      end
    join
    checkCount++;
    if (tx !== 1'b1) $display("FAIL busy_tx_idle: got %b want 1", tx); else passCount++;
    @(negedge clk);
    busRead(2'b11, v);
    checkCount++;
    if (v[0] !== 1'b0) $display("FAIL busy_no_restart: got %b want 0", v[0]); else passCount++;
    busRead(2'b00, v);
    checkCount++;
    if (v !== 8'hFF) $display("FAIL busy_txdata: got %h want ff", v); else passCount++;

    rxQ.push_back(8'h77);
    modelRxData = 8'h77;
    seen = 1'b0;
    fork
      sendFrame(8'h77, 1'b1);
      begin
        bus.readEnable  = 1'b1;
        bus.regSelect   = 2'b11;
        bus.dataIn      = 8'h02;
        bus.writeEnable = 1'b1;
        waited = 0;
        while (!seen && waited < 20 * CPB) begin
          @(negedge clk);
          #1;
          seen = bus.dataOut[1];
          waited++;
        end
        bus.writeEnable = 1'b0;
      end
    join
    checkCount++;
    if (seen !== 1'b1) $display("FAIL collision_seen: got %b want 1", seen); else passCount++;
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h02) $display("FAIL collision_status: got %h want 02", v); else passCount++;
    busRead(2'b01, v);
    checkCount++;
    if (v !== rxQ[0]) $display("FAIL collision_data: got %h want %h", v, rxQ[0]); else passCount++;
    void'(rxQ.pop_front());
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] v;
    busWrite(2'b00, 8'hC3);
    busWrite(2'b10, 8'h03);
    repeat (10) @(negedge clk);
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h03) $display("FAIL pre_reset_status: got %h want 03", v); else passCount++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkCount++;
    if (tx !== 1'b1) $display("FAIL midreset_tx: got %b want 1", tx); else passCount++;
    busRead(2'b11, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL midreset_status: got %h want 00", v); else passCount++;
    busRead(2'b00, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL midreset_txdata: got %h want 00", v); else passCount++;
    busRead(2'b01, v);
    checkCount++;
    if (v !== 8'h00) $display("FAIL midreset_rxdata: got %h want 00", v); else passCount++;
    busRead(2'b10, v);
    checkCount++;
    if (v !== 8'h02) $display("FAIL midreset_control: got %h want 02", v); else passCount++;
    repeat (2 * CPB) @(negedge clk);
    checkCount++;
    if (tx !== 1'b1) $display("FAIL midreset_tx_stays: got %b want 1", tx); else passCount++;
  endtask

  initial begin
    bus.readEnable  = 1'b0;
    bus.writeEnable = 1'b0;
    bus.regSelect   = 2'b00;
    bus.dataIn      = 8'h00;
    test_reset();
    test_tx();
    test_rx();
    test_overrun_frame();
    test_glitch();
    test_abort();
    test_back_to_back();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
